// File: rtl/tug_sequencer.sv
// tug_sequencer: game-flow controller for two-player tug-of-war.
// Drives the 6-bit screen code through idle, a 3/2/1/go countdown, a live
// barrier position, and a held winner screen. All outputs are registered.
module tug_sequencer #(
   parameter int STEP_CYCLES = 12_000_000,
   parameter int WIN_CYCLES  = 60_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       p1_btn,
   input  logic       p2_btn,
   output logic [5:0] screen,
   output logic       playing,
   output logic [1:0] winner
);

   localparam int MAX_CYCLES = (STEP_CYCLES > WIN_CYCLES) ? STEP_CYCLES : WIN_CYCLES;
   localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
   localparam logic [TW-1:0] WIN_LAST  = TW'(WIN_CYCLES - 1);

   localparam logic [5:0] POS_START  = 6'd23;
   localparam logic [5:0] POS_P1_WIN = 6'd30;
   localparam logic [5:0] POS_P2_WIN = 6'd16;
   localparam logic [5:0] SCR_BLANK  = 6'd0;
   localparam logic [5:0] SCR_GO     = 6'd31;
   localparam logic [5:0] SCR_ONE    = 6'd32;
   localparam logic [5:0] SCR_TWO    = 6'd33;
   localparam logic [5:0] SCR_THREE  = 6'd34;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      CD3,
      CD2,
      CD1,
      GO,
      PLAY,
      WIN
   } state_t;

   state_t        state;
   state_t        nextState;
   logic [TW-1:0] timer;
   logic [TW-1:0] timerNext;
   logic [5:0]    position;
   logic [5:0]    positionNext;
   logic [1:0]    winnerNext;
   logic [5:0]    screenNext;
   logic          playingNext;

   logic          startPrev;
   logic          p1Prev;
   logic          p2Prev;
   logic          startPress;
   logic          p1Press;
   logic          p2Press;
   logic          timedState;

   // Rising-edge detection, registered so presses are seen one cycle later.
   // A press only survives if the current state is one that listens for it,
   // so a start rising on the WIN->IDLE edge or a player rising on the
   // GO->PLAY edge is dropped rather than acted on a cycle late.
   always_ff @(posedge clk) begin
      if (reset) begin
         startPrev  <= 1'b0;
         p1Prev     <= 1'b0;
         p2Prev     <= 1'b0;
         startPress <= 1'b0;
         p1Press    <= 1'b0;
         p2Press    <= 1'b0;
      end else begin
         startPrev  <= start_btn;
         p1Prev     <= p1_btn;
         p2Prev     <= p2_btn;
         startPress <= start_btn & ~startPrev & (state == IDLE);
         p1Press    <= p1_btn & ~p1Prev & (state == PLAY);
         p2Press    <= p2_btn & ~p2Prev & (state == PLAY);
      end
   end

   // State, timer, position and the registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         position <= POS_START;
         winner   <= WIN_NONE;
         screen   <= SCR_BLANK;
         playing  <= 1'b0;
      end else begin
         state    <= nextState;
         timer    <= timerNext;
         position <= positionNext;
         winner   <= winnerNext;
         screen   <= screenNext;
         playing  <= playingNext;
      end
   end

   // Next-state, scoring and timer logic. A press that lands the barrier
   // on either end moves straight to WIN in the same update.
   always_comb begin
      nextState    = state;
      positionNext = position;
      winnerNext   = winner;
      timedState   = 1'b0;
      case (state)
         IDLE: begin
            if (startPress) begin
               nextState  = CD3;
               winnerNext = WIN_NONE;
            end
         end
         CD3: begin
            timedState = 1'b1;
            if (timer == STEP_LAST) nextState = CD2;
         end
         CD2: begin
            timedState = 1'b1;
            if (timer == STEP_LAST) nextState = CD1;
         end
         CD1: begin
            timedState = 1'b1;
            if (timer == STEP_LAST) nextState = GO;
         end
         GO: begin
            timedState = 1'b1;
            if (timer == STEP_LAST) begin
               nextState    = PLAY;
               positionNext = POS_START;
            end
         end
         PLAY: begin
            if (p1Press && !p2Press) begin
               positionNext = position + 6'd1;
            end else if (p2Press && !p1Press) begin
               positionNext = position - 6'd1;
            end
            if (positionNext == POS_P1_WIN) begin
               nextState  = WIN;
               winnerNext = WIN_P1;
            end else if (positionNext == POS_P2_WIN) begin
               nextState  = WIN;
               winnerNext = WIN_P2;
            end
         end
         WIN: begin
            timedState = 1'b1;
            if (timer == WIN_LAST) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase

      if (nextState != state) begin
         timerNext = '0;
      end else if (timedState) begin
         timerNext = timer + TW'(1);
      end else begin
         timerNext = '0;
      end
   end

   // Display code for the state being entered, so screen changes on the
   // same edge as the state itself.
   always_comb begin
      screenNext  = SCR_BLANK;
      playingNext = (nextState == PLAY);
      case (nextState)
         IDLE:    screenNext = SCR_BLANK;
         CD3:     screenNext = SCR_THREE;
         CD2:     screenNext = SCR_TWO;
         CD1:     screenNext = SCR_ONE;
         GO:      screenNext = SCR_GO;
         PLAY:    screenNext = positionNext;
         WIN:     screenNext = (winnerNext == WIN_P1) ? POS_P1_WIN : POS_P2_WIN;
         default: screenNext = SCR_BLANK;
      endcase
   end

endmodule

// File: tb/tb_tug_sequencer.sv
// tb_tug_sequencer: directed game scenarios followed by random button
// activity, every cycle compared against a phase-level game model.
module tb_tug_sequencer;

   localparam int STEP = 4;
   localparam int WIN  = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_btn = 1'b0;
   logic       p1_btn = 1'b0;
   logic       p2_btn = 1'b0;
   logic [5:0] screen;
   logic       playing;
   logic [1:0] winner;

   int total = 0;
   int bad = 0;

   // Model: mode 0 idle, 1 countdown (all four screens), 2 play, 3 win
   int mMode = 0;
   int mElapsed = 0;
   int mPos = 23;
   int mWinner = 0;
   bit mPrevS = 0, mPrevA = 0, mPrevB = 0;
   bit mPendS = 0, mPendA = 0, mPendB = 0;

   always #5 clk = ~clk;

   tug_sequencer #(
      .STEP_CYCLES(STEP),
      .WIN_CYCLES (WIN)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start_btn(start_btn),
      .p1_btn   (p1_btn),
      .p2_btn   (p2_btn),
      .screen   (screen),
      .playing  (playing),
      .winner   (winner)
   );

   // Single comparison point; X/Z on the DUT side counts as a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
      total++;
      if (observed !== 32'(expected)) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance the game model by one clock edge using the current inputs.
   // Presses are captured against the mode at the sampling edge and acted
   // on at the following edge.
   task automatic modelEdge();
      bit newS, newA, newB;
      if (reset) begin
         mMode = 0; mElapsed = 0; mPos = 23; mWinner = 0;
         mPrevS = 0; mPrevA = 0; mPrevB = 0;
         mPendS = 0; mPendA = 0; mPendB = 0;
      end else begin
         newS = start_btn && !mPrevS && (mMode == 0);
         newA = p1_btn && !mPrevA && (mMode == 2);
         newB = p2_btn && !mPrevB && (mMode == 2);
         mPrevS = start_btn; mPrevA = p1_btn; mPrevB = p2_btn;
         case (mMode)
            0: if (mPendS) begin
                  mMode = 1; mElapsed = 0; mWinner = 0;
               end
            1: begin
                  mElapsed++;
                  if (mElapsed == 4 * STEP) begin
                     mMode = 2; mElapsed = 0; mPos = 23;
                  end
               end
            2: begin
                  mPos += int'(mPendA) - int'(mPendB);
                  if (mPos == 30) begin
                     mMode = 3; mElapsed = 0; mWinner = 1;
                  end else if (mPos == 16) begin
                     mMode = 3; mElapsed = 0; mWinner = 2;
                  end
               end
            default: begin
                  mElapsed++;
                  if (mElapsed == WIN) begin
                     mMode = 0; mElapsed = 0;
                  end
               end
         endcase
         mPendS = newS; mPendA = newA; mPendB = newB;
      end
   endtask

   function automatic int expScreen();
      case (mMode)
         0:       return 0;
         1:       return 34 - mElapsed / STEP;
         2:       return mPos;
         default: return (mWinner == 1) ? 30 : 16;
      endcase
   endfunction

   // One clock: update the model on the edge, compare 1 time unit later.
   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("screen", screen, expScreen());
      checkOutput("playing", playing, (mMode == 2) ? 1 : 0);
      checkOutput("winner", winner, mWinner);
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic a, input logic b, input int n);
      reset = r; start_btn = s; p1_btn = a; p2_btn = b;
      repeat (n) tick();
   endtask

   task automatic pulseStart();
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
   endtask

   task automatic pulsePlayer(input logic a, input logic b, input int count);
      repeat (count) begin
         applyStimulus(0, 0, a, b, 1);
         applyStimulus(0, 0, 0, 0, 1);
      end
   endtask

   initial begin
      logic r, s, a, b;

      // Reset and countdown
      applyStimulus(1, 0, 0, 0, 2);
      applyStimulus(0, 0, 0, 0, 2);
      checkOutput("rst_screen", screen, 0);
      checkOutput("rst_playing", playing, 0);
      checkOutput("rst_winner", winner, 0);
      pulseStart();
      checkOutput("cd3_first", screen, 34);
      applyStimulus(0, 0, 0, 0, 4);
      checkOutput("cd2_first", screen, 33);
      applyStimulus(0, 0, 0, 0, 11);
      checkOutput("go_last", screen, 31);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("play_entry", screen, 23);
      checkOutput("play_entry_playing", playing, 1);

      // P1 win, held win screen, winner cleared by next start
      pulsePlayer(1, 0, 6);
      checkOutput("p1_at_29", screen, 29);
      pulsePlayer(1, 0, 1);
      checkOutput("p1_win_screen", screen, 30);
      checkOutput("p1_win_playing", playing, 0);
      checkOutput("p1_win_winner", winner, 1);
      applyStimulus(0, 0, 0, 0, 7);
      checkOutput("win_held", screen, 30);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("idle_after_win", screen, 0);
      checkOutput("idle_keeps_winner", winner, 1);
      pulseStart();
      checkOutput("start_clears_winner", winner, 0);
      applyStimulus(0, 0, 0, 0, 16);
      checkOutput("play_entry2", screen, 23);

      // Held button gives one decrement
      applyStimulus(0, 0, 0, 1, 10);
      checkOutput("held_p2", screen, 22);
      applyStimulus(0, 0, 0, 0, 1);
      pulsePlayer(0, 1, 1);
      checkOutput("p2_again", screen, 21);

      // Simultaneous presses cancel
      pulsePlayer(1, 0, 2);
      applyStimulus(0, 0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 2);
      checkOutput("both_pressed", screen, 23);

      // P2 win with an ignored start during WIN
      pulsePlayer(0, 1, 7);
      checkOutput("p2_win_screen", screen, 16);
      checkOutput("p2_win_winner", winner, 2);
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 6);
      checkOutput("win_ignores_start", screen, 16);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("idle_after_p2_win", screen, 0);

      // Early presses during countdown, last one rising on the GO->PLAY edge
      pulseStart();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 1, 0, 1);
         applyStimulus(0, 0, 0, 1, 1);
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("no_false_start", screen, 23);

      // Reset mid-game
      pulsePlayer(1, 0, 3);
      checkOutput("pos_26", screen, 26);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("midgame_rst_screen", screen, 0);
      checkOutput("midgame_rst_playing", playing, 0);
      checkOutput("midgame_rst_winner", winner, 0);
      applyStimulus(0, 0, 0, 0, 1);
      pulseStart();
      checkOutput("restart_cd3", screen, 34);
      applyStimulus(0, 0, 0, 0, 16);
      checkOutput("restart_play", screen, 23);

      // Random button activity with occasional resets
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(299) == 0);
         s = start_btn ^ ($urandom_range(19) == 0);
         a = p1_btn ^ ($urandom_range((i < 1500) ? 2 : 5) == 0);
         b = p2_btn ^ ($urandom_range((i < 1500) ? 5 : 2) == 0);
         applyStimulus(r, s, a, b, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
